writeback_stage: RTL and testbench

Write-back stage directly downstream of the two-stage execution pipeline. It consumes the execution result, the valid flag, the instruction word and the PC, and buffers them in a small in-order FIFO. It drains each entry into the register-file write port under a valid/ready handshake and retires instructions in order, keeping a 64-bit retired-instruction counter. It also forwards pending, not-yet-written results to two operand lookup ports and throttles the execution stage when the buffer is nearly full.

---
 rtl/writeback_stage_pkg.sv | 27 ++
 rtl/writeback_stage_wb_fifo.sv | 82 ++++++++
 rtl/writeback_stage.sv | 130 +++++++++++++
 tb/tb_writeback_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared RV32I decode constants for the write-back stage.
// Opcode values and the rd field position used to decide whether an entry writes the register file.
package writeback_stage_pkg;

  localparam int OPC_W  = 7;
  localparam int RD_W   = 5;
  localparam int RD_LSB = 7;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  // x0 is hardwired, so a write to it is treated as no write at all.
  function automatic logic writes_rd(input logic [OPC_W-1:0] opcode, input logic [RD_W-1:0] rd);
    logic wr;
    case (opcode)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: wr = 1'b1;
      default: wr = 1'b0;
    endcase
    return wr && (rd != '0);
  endfunction

endpackage

// File: rtl/writeback_stage_wb_fifo.sv
// In-order circular buffer for pending write-back entries.
// Exposes every slot plus a per-slot valid vector so the top level can scan for forwarding.
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [WIDTH-1:0]            wdata,
  output logic [WIDTH-1:0]            rdata,
  output logic                        full,
  output logic                        empty,
  output logic [CNT_W-1:0]            count,
  output logic [PTR_W-1:0]            rd_ptr,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][WIDTH-1:0] entries
);

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign entries = mem_q;

  // A pop frees the head slot in the same cycle, so push at full is accepted alongside it.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_comb begin
    int idx;
    idx         = 0;
    entry_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(rd_ptr_q) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (k < int'(count_q)) entry_valid[idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

endmodule

// File: rtl/writeback_stage.sv
// Write-back stage: buffers execution results, drains them to the register file in order,
// retires instructions, forwards pending results and throttles upstream when nearly full.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uop_valid_in,
  input  logic [DATA_WIDTH-1:0] result_in,
  input  logic [INST_WIDTH-1:0] instruction_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  rf_wr_en,
  output logic [4:0]            rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  input  logic                  rf_wr_ready,
  input  logic [4:0]            fwd_rs1_addr,
  input  logic [4:0]            fwd_rs2_addr,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data,
  output logic                  wb_stall,
  output logic                  retire_valid,
  output logic [ADDR_WIDTH-1:0] retire_pc,
  output logic [INST_WIDTH-1:0] retire_instruction,
  output logic [63:0]           instret,
  output logic                  overflow_err
);

  // Entry layout, LSB first: instruction, pc, wr, rd, result.
  localparam int PC_LSB  = INST_WIDTH;
  localparam int WR_POS  = PC_LSB + ADDR_WIDTH;
  localparam int RDF_LSB = WR_POS + 1;
  localparam int RES_LSB = RDF_LSB + RD_W;
  localparam int EW      = RES_LSB + DATA_WIDTH;
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic [RD_W-1:0]             in_rd;
  logic                        in_wr;
  logic [EW-1:0]               wdata, head;
  logic                        full, empty, pop;
  logic                        head_valid, head_wr;
  logic [CNT_W-1:0]            count;
  logic [PTR_W-1:0]            rd_ptr;
  logic [DEPTH-1:0]            entry_valid;
  logic [DEPTH-1:0][EW-1:0]    entries;
  logic [63:0]                 instret_q, instret_d;
  logic                        overflow_q, overflow_d;

  assign in_rd = instruction_in[RD_LSB +: RD_W];
  assign in_wr = writes_rd(instruction_in[OPC_W-1:0], in_rd);
  assign wdata = {result_in, in_rd, in_wr, pc_in, instruction_in};

  wb_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (uop_valid_in),
    .pop         (pop),
    .wdata       (wdata),
    .rdata       (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .rd_ptr      (rd_ptr),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  // Nothing writes or retires while reset is held, even though the old count is still visible.
  assign head_valid = !empty && !reset;
  assign head_wr    = head[WR_POS];
  assign rf_wr_en   = head_valid && head_wr;
  assign pop        = head_valid && (!head_wr || rf_wr_ready);

  assign rf_wr_addr         = rf_wr_en ? head[RDF_LSB +: RD_W] : '0;
  assign rf_wr_data         = rf_wr_en ? head[RES_LSB +: DATA_WIDTH] : '0;
  assign retire_valid       = pop;
  assign retire_pc          = head_valid ? head[PC_LSB +: ADDR_WIDTH] : '0;
  assign retire_instruction = head_valid ? head[INST_WIDTH-1:0] : '0;

  assign wb_stall     = (count >= CNT_W'(DEPTH - 1));
  assign instret      = instret_q;
  assign overflow_err = overflow_q;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    int idx;
    idx          = 0;
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = int'(rd_ptr) + k;
      if (idx >= DEPTH) idx = idx - DEPTH;
      if (entry_valid[idx] && entries[idx][WR_POS]) begin
        if (fwd_rs1_addr != '0 && entries[idx][RDF_LSB +: RD_W] == fwd_rs1_addr) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = entries[idx][RES_LSB +: DATA_WIDTH];
        end
        if (fwd_rs2_addr != '0 && entries[idx][RDF_LSB +: RD_W] == fwd_rs2_addr) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = entries[idx][RES_LSB +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    instret_d  = instret_q + 64'(pop);
    overflow_d = overflow_q || (uop_valid_in && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      instret_q  <= instret_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: stimulus queues expected writes/retires,
// a negedge monitor compares them as the DUT presents them.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        uop_valid_in;
  logic [31:0] result_in, instruction_in, pc_in;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic        rf_wr_ready;
  logic [4:0]  fwd_rs1_addr, fwd_rs2_addr;
  logic        fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        wb_stall, retire_valid;
  logic [31:0] retire_pc, retire_instruction;
  logic [63:0] instret;
  logic        overflow_err;

  int errors = 0;
  int checks = 0;

  logic [4:0]  exp_wr_addr[$];
  logic [31:0] exp_wr_data[$];
  logic [31:0] exp_ret_pc[$];
  logic [31:0] exp_ret_inst[$];

  writeback_stage dut (
    .clk(clk), .reset(reset), .uop_valid_in(uop_valid_in), .result_in(result_in),
    .instruction_in(instruction_in), .pc_in(pc_in), .rf_wr_en(rf_wr_en),
    .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data), .rf_wr_ready(rf_wr_ready),
    .fwd_rs1_addr(fwd_rs1_addr), .fwd_rs2_addr(fwd_rs2_addr),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .wb_stall(wb_stall), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_instruction(retire_instruction), .instret(instret), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // has_wr / stored are hand-decided per vector, not decoded from the instruction.
  task automatic issue(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] pc,
                       input bit has_wr, input bit stored);
    uop_valid_in   = 1'b1;
    instruction_in = inst;
    result_in      = res;
    pc_in          = pc;
    if (stored) begin
      if (has_wr) begin
        exp_wr_addr.push_back(inst[11:7]);
        exp_wr_data.push_back(res);
      end
      exp_ret_pc.push_back(pc);
      exp_ret_inst.push_back(inst);
    end
  endtask

  task automatic idle();
    uop_valid_in   = 1'b0;
    instruction_in = '0;
    result_in      = '0;
    pc_in          = '0;
  endtask

  always @(negedge clk) begin
    if (rf_wr_en && rf_wr_ready) begin
      if (exp_wr_addr.size() == 0) begin
        chk("wr_unexpected", {59'd0, rf_wr_addr}, 64'hdead);
      end else begin
        chk("wr_addr", 64'(rf_wr_addr), 64'(exp_wr_addr.pop_front()));
        chk("wr_data", 64'(rf_wr_data), 64'(exp_wr_data.pop_front()));
      end
    end
    if (retire_valid) begin
      if (exp_ret_pc.size() == 0) begin
        chk("retire_unexpected", 64'(retire_pc), 64'hdead);
      end else begin
        chk("retire_pc", 64'(retire_pc), 64'(exp_ret_pc.pop_front()));
        chk("retire_inst", 64'(retire_instruction), 64'(exp_ret_inst.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    rf_wr_ready = 1'b1;
    fwd_rs1_addr = '0;
    fwd_rs2_addr = '0;
    idle();
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_wr_en", 64'(rf_wr_en), 64'd0);
    chk("rst_stall", 64'(wb_stall), 64'd0);
    chk("rst_retire", 64'(retire_valid), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_wr_data", 64'(rf_wr_data), 64'd0);

    // ADDI x5 -> write x5=0x1234 at N+1, instret at N+2
    issue(32'h0000_0293, 32'h1234, 32'h100, 1'b1, 1'b1);
    fwd_rs1_addr = 5'd5;
    tick();
    idle();
    #1;
    chk("t1_wr_en", 64'(rf_wr_en), 64'd1);
    chk("t1_addr", 64'(rf_wr_addr), 64'd5);
    chk("t1_data", 64'(rf_wr_data), 64'h1234);
    chk("t1_retire", 64'(retire_valid), 64'd1);
    chk("t1_instret_n1", instret, 64'd0);
    chk("t1_fwd_hit", 64'(fwd_rs1_hit), 64'd1);
    chk("t1_fwd_data", 64'(fwd_rs1_data), 64'h1234);
    tick();
    chk("t1_instret_n2", instret, 64'd1);
    chk("t1_empty_wr_en", 64'(rf_wr_en), 64'd0);
    fwd_rs1_addr = '0;

    // NOP (addi x0) -> retire only
    issue(32'h0000_0013, 32'h55, 32'h104, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    chk("t2_wr_en", 64'(rf_wr_en), 64'd0);
    chk("t2_retire", 64'(retire_valid), 64'd1);
    tick();
    chk("t2_instret", instret, 64'd2);

    // Backpressure: x6 then x7 held, then drained in order
    rf_wr_ready = 1'b0;
    issue(32'h0000_0313, 32'h66, 32'h108, 1'b1, 1'b1);
    tick();
    chk("t3_stall_occ1", 64'(wb_stall), 64'd1);
    chk("t3_hold_addr0", 64'(rf_wr_addr), 64'd6);
    issue(32'h0000_0393, 32'h77, 32'h10c, 1'b1, 1'b1);
    tick();
    idle();
    chk("t3_hold_addr1", 64'(rf_wr_addr), 64'd6);
    chk("t3_hold_data1", 64'(rf_wr_data), 64'h66);
    chk("t3_no_retire", 64'(retire_valid), 64'd0);
    tick();
    chk("t3_hold_addr2", 64'(rf_wr_addr), 64'd6);
    rf_wr_ready = 1'b1;
    tick();
    chk("t3_next_addr", 64'(rf_wr_addr), 64'd7);
    tick();
    chk("t3_drained", 64'(rf_wr_en), 64'd0);
    chk("t3_instret", instret, 64'd4);
    chk("t3_stall_clear", 64'(wb_stall), 64'd0);

    // Two pending x9 writes: youngest wins, x0 never hits
    rf_wr_ready = 1'b0;
    issue(32'h0000_0493, 32'hA, 32'h110, 1'b1, 1'b1);
    tick();
    issue(32'h0000_0493, 32'hB, 32'h114, 1'b1, 1'b1);
    tick();
    idle();
    fwd_rs1_addr = 5'd9;
    fwd_rs2_addr = 5'd0;
    #1;
    chk("t4_rs1_hit", 64'(fwd_rs1_hit), 64'd1);
    chk("t4_rs1_data", 64'(fwd_rs1_data), 64'hB);
    chk("t4_rs2_hit", 64'(fwd_rs2_hit), 64'd0);
    chk("t4_rs2_data", 64'(fwd_rs2_data), 64'd0);
    fwd_rs2_addr = 5'd8;
    #1;
    chk("t4_miss_hit", 64'(fwd_rs2_hit), 64'd0);
    chk("t4_miss_data", 64'(fwd_rs2_data), 64'd0);

    // Full with ready low: third push is dropped and flags overflow
    chk("t5_full_stall", 64'(wb_stall), 64'd1);
    issue(32'h0000_0513, 32'hC, 32'h118, 1'b1, 1'b0);
    tick();
    idle();
    chk("t5_ovf", 64'(overflow_err), 64'd1);
    chk("t5_head_kept", 64'(rf_wr_data), 64'hA);
    fwd_rs2_addr = 5'd10;
    #1;
    chk("t5_dropped_fwd", 64'(fwd_rs2_hit), 64'd0);

    // Push + pop at full keeps occupancy at 2
    rf_wr_ready = 1'b1;
    issue(32'h0000_0593, 32'hD, 32'h11c, 1'b1, 1'b1);
    tick();
    idle();
    rf_wr_ready = 1'b0;
    fwd_rs1_addr = 5'd11;
    fwd_rs2_addr = 5'd9;
    #1;
    chk("t5_pp_head", 64'(rf_wr_data), 64'hB);
    chk("t5_pp_stall", 64'(wb_stall), 64'd1);
    chk("t5_pp_fwd_new", 64'(fwd_rs1_data), 64'hD);
    chk("t5_pp_fwd_old", 64'(fwd_rs2_data), 64'hB);
    chk("t5_pp_instret", instret, 64'd5);
    chk("t5_ovf_sticky", 64'(overflow_err), 64'd1);

    // Reset with two pending entries discards them
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_wr_addr.delete();
    exp_wr_data.delete();
    exp_ret_pc.delete();
    exp_ret_inst.delete();
    #1;
    chk("t6_wr_en", 64'(rf_wr_en), 64'd0);
    chk("t6_instret", instret, 64'd0);
    chk("t6_ovf", 64'(overflow_err), 64'd0);
    chk("t6_stall", 64'(wb_stall), 64'd0);
    chk("t6_fwd", 64'(fwd_rs1_hit), 64'd0);

    // Post-reset transaction still flows
    rf_wr_ready = 1'b1;
    issue(32'h0000_0613, 32'h1C, 32'h200, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    chk("t7_instret", instret, 64'd1);
    tick();
    chk("end_wr_queue", 64'(exp_wr_addr.size()), 64'd0);
    chk("end_ret_queue", 64'(exp_ret_pc.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
